// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg
//   Shared definitions for the memory-stage load/store unit:
//   - funct3 encodings for loads and stores
//   - FSM state encoding
//   - access-size type and the funct3 -> size decode helper
package rv_lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  // Access width from funct3. Any encoding that is not a byte/half form
  // (including the reserved ones) is handled as a full word.
  function automatic lsu_size_t f_size(input logic [2:0] funct3, input logic is_store);
    lsu_size_t size;
    size = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_SB:   size = SZ_BYTE;
        F3_SH:   size = SZ_HALF;
        F3_SW:   size = SZ_WORD;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: size = SZ_BYTE;
        F3_LH, F3_LHU: size = SZ_HALF;
        F3_LW:         size = SZ_WORD;
        default:       size = SZ_WORD;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/m_lsu_align.sv
// lsu_align
//   Purely combinational lane logic for the LSU.
//   Request side (current M-stage access):
//     i_size, i_off, i_is_store, i_store_data -> o_wstrb, o_wdata, o_misalign
//   Response side (latched access):
//     i_ld_size, i_ld_unsigned, i_ld_off, i_rdata -> o_load_data
module lsu_align
  import rv_lsu_pkg::*;
(
  input  lsu_size_t   i_size,
  input  logic [1:0]  i_off,
  input  logic        i_is_store,
  input  logic [31:0] i_store_data,
  input  lsu_size_t   i_ld_size,
  input  logic        i_ld_unsigned,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic [31:0] w_shifted;

  // Bring the addressed byte lane down to bit 0.
  assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

  // Store strobes and lane-replicated write data; loads drive no strobes.
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'h0000_0000;
    if (i_is_store) begin
      case (i_size)
        SZ_BYTE: begin
          o_wstrb = 4'b0001 << i_off;
          o_wdata = {4{i_store_data[7:0]}};
        end
        SZ_HALF: begin
          o_wstrb = 4'b0011 << i_off;
          o_wdata = {2{i_store_data[15:0]}};
        end
        default: begin
          o_wstrb = 4'b1111;
          o_wdata = i_store_data;
        end
      endcase
    end else begin
      o_wstrb = 4'b0000;
      o_wdata = 32'h0000_0000;
    end
  end

  // Natural alignment check on the current access.
  always_comb begin
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: o_misalign = 1'b0;
      SZ_HALF: o_misalign = i_off[0];
      default: o_misalign = |i_off;
    endcase
  end

  // Sign/zero extension of the shifted load data.
  always_comb begin
    o_load_data = w_shifted;
    case (i_ld_size)
      SZ_BYTE: begin
        if (i_ld_unsigned) begin
          o_load_data = {24'h00_0000, w_shifted[7:0]};
        end else begin
          o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
        end
      end
      SZ_HALF: begin
        if (i_ld_unsigned) begin
          o_load_data = {16'h0000, w_shifted[15:0]};
        end else begin
          o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
        end
      end
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/m_lsu.sv
// m_lsu
//   Memory-stage load/store unit between the E/M and M/RB pipeline registers.
//   Ports:
//     i_clk, i_rst                       clock, synchronous active-high reset
//     i_mem_ren_M, i_mem_wen_M           load / store present in M
//     i_funct3_M, i_alu_result_M         access type, effective byte address
//     i_rs2_data_M, i_flush_M            store data, kill the M instruction
//     o_dmem_req_*, i_dmem_req_ready     request channel (valid/ready)
//     i_dmem_rsp_valid, i_dmem_rsp_rdata load response channel
//     o_mem_rdata_M                      aligned/extended load result (registered)
//     o_lsu_stall_M                      hold IF..M this cycle
//     o_misalign_M                       misaligned access seen in IDLE
//   One request outstanding at a time; the request fields come straight from
//   latches so they stay stable while the memory back-pressures.
module m_lsu
  import rv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mem_ren_M,
  input  logic            i_mem_wen_M,
  input  logic [2:0]      i_funct3_M,
  input  logic [XLEN-1:0] i_alu_result_M,
  input  logic [XLEN-1:0] i_rs2_data_M,
  input  logic            i_flush_M,
  output logic            o_dmem_req_valid,
  input  logic            i_dmem_req_ready,
  output logic            o_dmem_req_we,
  output logic [XLEN-1:0] o_dmem_req_addr,
  output logic [XLEN-1:0] o_dmem_req_wdata,
  output logic [3:0]      o_dmem_req_wstrb,
  input  logic            i_dmem_rsp_valid,
  input  logic [XLEN-1:0] i_dmem_rsp_rdata,
  output logic [XLEN-1:0] o_mem_rdata_M,
  output logic            o_lsu_stall_M,
  output logic            o_misalign_M
);

  lsu_state_t  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic [31:0] r_rdata;

  logic        w_access;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_start;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  // A simultaneous load+store request is handled as a load.
  assign w_access   = (i_mem_ren_M | i_mem_wen_M) & ~i_flush_M;
  assign w_is_store = i_mem_wen_M & ~i_mem_ren_M;
  assign w_start    = (r_state == S_IDLE) & w_access & ~w_misalign;

  lsu_align u_align (
    .i_size        (f_size(i_funct3_M, w_is_store)),
    .i_off         (i_alu_result_M[1:0]),
    .i_is_store    (w_is_store),
    .i_store_data  (i_rs2_data_M),
    .i_ld_size     (f_size(r_funct3, 1'b0)),
    .i_ld_unsigned (r_funct3[2]),
    .i_ld_off      (r_addr[1:0]),
    .i_rdata       (i_dmem_rsp_rdata),
    .o_wstrb       (w_wstrb),
    .o_wdata       (w_wdata),
    .o_load_data   (w_load_data),
    .o_misalign    (w_misalign)
  );

  // Access FSM, request latches and load result register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'h0000_0000;
      r_funct3 <= 3'b000;
      r_wdata  <= 32'h0000_0000;
      r_wstrb  <= 4'b0000;
      r_we     <= 1'b0;
      r_rdata  <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr   <= i_alu_result_M;
            r_funct3 <= i_funct3_M;
            r_wdata  <= w_wdata;
            r_wstrb  <= w_wstrb;
            r_we     <= w_is_store;
            r_state  <= S_REQ;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_REQ: begin
          // Once accepted the request cannot be withdrawn: a store completes,
          // a flushed load still has to swallow its response.
          if (i_dmem_req_ready) begin
            if (r_we) begin
              r_state <= S_DONE;
            end else if (i_flush_M) begin
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_RESP;
            end
          end else if (i_flush_M) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_RESP: begin
          // Flush wins over a same-cycle response, whose data is then dropped.
          if (i_flush_M) begin
            if (i_dmem_rsp_valid) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (i_dmem_rsp_valid) begin
            r_rdata <= w_load_data;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RESP;
          end
        end
        S_DRAIN: begin
          if (i_dmem_rsp_valid) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall: the starting cycle in IDLE plus every waiting state; DONE releases.
  always_comb begin
    o_lsu_stall_M = 1'b0;
    case (r_state)
      S_IDLE:  o_lsu_stall_M = w_start;
      S_REQ:   o_lsu_stall_M = 1'b1;
      S_RESP:  o_lsu_stall_M = 1'b1;
      S_DRAIN: o_lsu_stall_M = 1'b1;
      S_DONE:  o_lsu_stall_M = 1'b0;
      default: o_lsu_stall_M = 1'b0;
    endcase
  end

  assign o_misalign_M     = (r_state == S_IDLE) & w_access & w_misalign;
  assign o_dmem_req_valid = (r_state == S_REQ);
  assign o_dmem_req_we    = r_we;
  assign o_dmem_req_addr  = {r_addr[31:2], 2'b00};
  assign o_dmem_req_wdata = r_wdata;
  assign o_dmem_req_wstrb = r_wstrb;
  assign o_mem_rdata_M    = r_rdata;

endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu
//   Self-checking bench for m_lsu: directed vectors followed by randomized
//   accesses, each compared against a transaction-level reference model and
//   a small responder that drives ready/response timing.
module tb_m_lsu;

  logic        clk;
  logic        rst;
  logic        ren;
  logic        wen;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        misalign;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rd;
  int          nstall;

  m_lsu dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_mem_ren_M      (ren),
    .i_mem_wen_M      (wen),
    .i_funct3_M       (f3),
    .i_alu_result_M   (addr),
    .i_rs2_data_M     (wd),
    .i_flush_M        (flush),
    .o_dmem_req_valid (req_valid),
    .i_dmem_req_ready (req_ready),
    .o_dmem_req_we    (req_we),
    .o_dmem_req_addr  (req_addr),
    .o_dmem_req_wdata (req_wdata),
    .o_dmem_req_wstrb (req_wstrb),
    .i_dmem_rsp_valid (rsp_valid),
    .i_dmem_rsp_rdata (rsp_rdata),
    .o_mem_rdata_M    (mem_rdata),
    .o_lsu_stall_M    (stall),
    .o_misalign_M     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Access size in bytes from the funct3 rules.
  function automatic int acc_bytes(input logic [2:0] fn, input logic is_store);
    int lo;
    if (is_store) begin
      if (fn == 3'd0) return 1;
      if (fn == 3'd1) return 2;
      return 4;
    end
    lo = int'(fn) % 4;
    if (lo == 0) return 1;
    if (lo == 1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] fn, input int off, input logic [31:0] w);
    int unsigned v;
    int sz;
    sz = acc_bytes(fn, 1'b0);
    v  = w / (32'd1 << (8 * off));
    if (sz == 1) begin
      v = v % 256;
      if (fn[2] == 1'b0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v % 65536;
      if (fn[2] == 1'b0 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic drop_inputs();
    ren = 1'b0; wen = 1'b0; flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
  endtask

  // One access from IDLE to completion. flush_mode: 0 none, 1 flush while
  // waiting for ready, 2 flush in the response wait (loads only).
  task automatic run_access(input logic ren_i, input logic wen_i, input logic [2:0] f3_i,
                            input logic [31:0] a_i, input logic [31:0] d_i, input int flush_mode,
                            input int ready_lo, input int rsp_dly, input logic [31:0] rsp_word,
                            output int stalls);
    logic        is_store;
    int          sz;
    int          off;
    logic        mis;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    int          fm;
    is_store = wen_i && !ren_i;
    sz       = acc_bytes(f3_i, is_store);
    off      = int'(a_i % 4);
    mis      = (off % sz) != 0;
    e_addr   = a_i - 32'(off);
    e_wstrb  = 4'b0000;
    e_wdata  = 32'h0;
    if (is_store) begin
      e_wstrb = 4'(((1 << sz) - 1) << off);
      if (sz == 1) e_wdata = (d_i % 256) * 32'h0101_0101;
      else if (sz == 2) e_wdata = (d_i % 65536) * 32'h0001_0001;
      else e_wdata = d_i;
    end
    fm = (is_store && flush_mode == 2) ? 0 : flush_mode;
    stalls = 0;

    @(posedge clk); #1;
    ren = ren_i; wen = wen_i; f3 = f3_i; addr = a_i; wd = d_i;
    flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("misalign", 32'(misalign), 32'(mis));
    if (mis) begin
      check_eq("mis_stall", 32'(stall), 32'd0);
      check_eq("mis_valid", 32'(req_valid), 32'd0);
      @(posedge clk); #1; drop_inputs();
      @(negedge clk);
      check_eq("mis_novalid", 32'(req_valid), 32'd0);
      return;
    end
    check_eq("start_stall", 32'(stall), 32'd1);
    check_eq("start_valid", 32'(req_valid), 32'd0);
    if (stall) stalls++;

    // Request phase: ready held low ready_lo cycles.
    for (int c = 0; c <= ready_lo; c++) begin
      @(posedge clk); #1;
      if (c == ready_lo) begin
        if (fm == 1) flush = 1'b1;
        else req_ready = 1'b1;
      end
      @(negedge clk);
      check_eq("req_valid", 32'(req_valid), 32'd1);
      check_eq("req_addr", req_addr, e_addr);
      check_eq("req_wstrb", 32'(req_wstrb), 32'(e_wstrb));
      check_eq("req_we", 32'(req_we), 32'(is_store));
      if (is_store) check_eq("req_wdata", req_wdata, e_wdata);
      check_eq("req_stall", 32'(stall), 32'd1);
      if (stall) stalls++;
    end
    @(posedge clk); #1;
    req_ready = 1'b0;

    if (fm == 1) begin
      drop_inputs();
      @(negedge clk);
      check_eq("flushreq_valid", 32'(req_valid), 32'd0);
      check_eq("flushreq_stall", 32'(stall), 32'd0);
      check_eq("flushreq_rdata", mem_rdata, exp_rd);
      return;
    end
    if (is_store) begin
      @(negedge clk);
      check_eq("st_done_stall", 32'(stall), 32'd0);
      check_eq("st_done_valid", 32'(req_valid), 32'd0);
      check_eq("st_rdata_kept", mem_rdata, exp_rd);
      @(posedge clk); #1; drop_inputs();
      return;
    end
    if (fm == 2) begin
      flush = 1'b1;
      @(negedge clk);
      check_eq("resp_stall", 32'(stall), 32'd1);
      @(posedge clk); #1; drop_inputs();
      for (int c = 0; c < rsp_dly; c++) begin
        @(negedge clk);
        check_eq("drain_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
      end
      rsp_valid = 1'b1; rsp_rdata = rsp_word;
      @(negedge clk);
      check_eq("drain_stall", 32'(stall), 32'd1);
      @(posedge clk); #1; rsp_valid = 1'b0;
      @(negedge clk);
      check_eq("drain_done_stall", 32'(stall), 32'd0);
      check_eq("drain_rdata_kept", mem_rdata, exp_rd);
      return;
    end
    for (int c = 0; c < rsp_dly; c++) begin
      @(negedge clk);
      check_eq("resp_stall", 32'(stall), 32'd1);
      check_eq("resp_valid_low", 32'(req_valid), 32'd0);
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    rsp_valid = 1'b1; rsp_rdata = rsp_word;
    @(negedge clk);
    check_eq("resp_stall", 32'(stall), 32'd1);
    if (stall) stalls++;
    @(posedge clk); #1; rsp_valid = 1'b0;
    exp_rd = model_load(f3_i, off, rsp_word);
    @(negedge clk);
    check_eq("ld_done_stall", 32'(stall), 32'd0);
    check_eq("ld_rdata", mem_rdata, exp_rd);
    @(posedge clk); #1; drop_inputs();
  endtask

  initial begin
    logic        r_ren;
    logic        r_wen;
    logic [2:0]  r_f3;
    int          fsel;
    int          fmode;
    rst = 1'b1; f3 = 3'b000; addr = 32'h0; wd = 32'h0; rsp_rdata = 32'h0;
    drop_inputs();
    exp_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(req_valid), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'h0);
    check_eq("rst_addr", req_addr, 32'h0);
    check_eq("rst_wstrb", 32'(req_wstrb), 32'd0);
    check_eq("rst_wdata", req_wdata, 32'h0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);

    // Directed vectors.
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, nstall);
    check_eq("lw_stalls", 32'(nstall), 32'd3);
    check_eq("lw_data", mem_rdata, 32'hDEAD_BEEF);
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 0, 32'h80FF_7F01, nstall);
    check_eq("lb_data", mem_rdata, 32'hFFFF_FF80);
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 1, 32'h80FF_7F01, nstall);
    check_eq("lbu_data", mem_rdata, 32'h0000_0080);
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 0, 32'h80FF_7F01, nstall);
    check_eq("lh_data", mem_rdata, 32'hFFFF_80FF);
    run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 0, 0, 0, 32'h80FF_7F01, nstall);
    check_eq("lhu_data", mem_rdata, 32'h0000_7F01);
    run_access(1'b0, 1'b1, 3'b000, 32'h101, 32'hAB, 0, 0, 0, 32'h0, nstall);
    check_eq("sb_stalls", 32'(nstall), 32'd2);
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234, 0, 5, 0, 32'h0, nstall);
    check_eq("sh_stalls", 32'(nstall), 32'd7);
    run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 0, 32'h0, nstall);
    run_access(1'b0, 1'b1, 3'b001, 32'h101, 32'h55, 0, 0, 0, 32'h0, nstall);
    run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 2, 0, 1, 32'h1111_1111, nstall);
    check_eq("drain_keeps", mem_rdata, 32'h0000_7F01);

    // Response pulse while idle must be ignored.
    @(posedge clk); #1; rsp_valid = 1'b1; rsp_rdata = 32'h2222_2222;
    @(posedge clk); #1; rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_rsp_ignored", mem_rdata, exp_rd);

    // Reset while the request is pending.
    @(posedge clk); #1; ren = 1'b1; f3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1; rst = 1'b1; drop_inputs();
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(req_valid), 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(req_valid), 32'd0);
    check_eq("mid_rst_stall", 32'(stall), 32'd0);
    exp_rd = 32'h0;
    check_eq("mid_rst_rdata", mem_rdata, exp_rd);

    // Randomized accesses.
    for (int i = 0; i < 200; i++) begin
      r_ren = 1'($urandom_range(0, 1));
      r_wen = r_ren ? ($urandom_range(0, 3) == 0) : 1'b1;
      r_f3  = 3'($urandom_range(0, 7));
      fsel  = int'($urandom_range(0, 5));
      fmode = (fsel == 4) ? 1 : ((fsel == 5) ? 2 : 0);
      run_access(r_ren, r_wen, r_f3, $urandom, $urandom, fmode,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom, nstall);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
